// File: rtl/dual_issue_sched.sv
// Dual-pipe issue scheduler: per-register countdown scoreboard plus a FULL/HALF
// pair-splitting FSM between decode and register fetch.
module dual_issue_sched #(
  parameter int NUM_REGS = 128,
  parameter int ADDR_WD  = 7,
  parameter int LAT_WD   = 3,
  parameter int STALL_WD = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                pair_valid_i,
  output logic                pair_ready_o,
  input  logic                ep_first_i,
  input  logic                ep_vld_i,
  input  logic                op_vld_i,
  input  logic                ep_wr_i,
  input  logic                op_wr_i,
  input  logic [ADDR_WD-1:0]  ep_rt_i,
  input  logic [ADDR_WD-1:0]  ep_ra_i,
  input  logic [ADDR_WD-1:0]  ep_rb_i,
  input  logic [ADDR_WD-1:0]  ep_rc_i,
  input  logic [ADDR_WD-1:0]  op_rt_i,
  input  logic [ADDR_WD-1:0]  op_ra_i,
  input  logic [ADDR_WD-1:0]  op_rb_i,
  input  logic [ADDR_WD-1:0]  op_rc_i,
  input  logic [2:0]          ep_ruse_i,
  input  logic [2:0]          op_ruse_i,
  input  logic [LAT_WD-1:0]   ep_lat_i,
  input  logic [LAT_WD-1:0]   op_lat_i,
  output logic                issue_ep_vld_o,
  output logic                issue_op_vld_o,
  output logic [STALL_WD-1:0] stall_cnt_o
);

  typedef enum logic {S_FULL, S_HALF} state_t;

  state_t              state_q, state_d;
  logic [LAT_WD-1:0]   cnt_q [NUM_REGS];
  logic                issue_ep_q, issue_ep_d;
  logic                issue_op_q, issue_op_d;
  logic                ready_d;
  logic [STALL_WD-1:0] stall_q;

  // A count of 1 expires at this edge, so the producer is forwardable now;
  // this gives a consumer issue exactly lat cycles after its producer.
  function automatic logic src_ok(input logic use_b, input logic [LAT_WD-1:0] c);
    return !use_b || (c <= LAT_WD'(1));
  endfunction

  logic ep_rdy, op_rdy;
  assign ep_rdy = !ep_vld_i ||
                  (src_ok(ep_ruse_i[2], cnt_q[ep_ra_i]) &&
                   src_ok(ep_ruse_i[1], cnt_q[ep_rb_i]) &&
                   src_ok(ep_ruse_i[0], cnt_q[ep_rc_i]));
  assign op_rdy = !op_vld_i ||
                  (src_ok(op_ruse_i[2], cnt_q[op_ra_i]) &&
                   src_ok(op_ruse_i[1], cnt_q[op_rb_i]) &&
                   src_ok(op_ruse_i[0], cnt_q[op_rc_i]));

  logic               old_wr, yng_wr, old_rdy, yng_rdy, yng_reads, split;
  logic [ADDR_WD-1:0] old_rt, yng_rt, yng_ra, yng_rb, yng_rc;
  logic [2:0]         yng_ruse;

  assign old_wr   = ep_first_i ? ep_wr_i   : op_wr_i;
  assign old_rt   = ep_first_i ? ep_rt_i   : op_rt_i;
  assign old_rdy  = ep_first_i ? ep_rdy    : op_rdy;
  assign yng_wr   = ep_first_i ? op_wr_i   : ep_wr_i;
  assign yng_rt   = ep_first_i ? op_rt_i   : ep_rt_i;
  assign yng_ra   = ep_first_i ? op_ra_i   : ep_ra_i;
  assign yng_rb   = ep_first_i ? op_rb_i   : ep_rb_i;
  assign yng_rc   = ep_first_i ? op_rc_i   : ep_rc_i;
  assign yng_ruse = ep_first_i ? op_ruse_i : ep_ruse_i;
  assign yng_rdy  = ep_first_i ? op_rdy    : ep_rdy;

  assign yng_reads = (yng_ruse[2] && (yng_ra == old_rt)) ||
                     (yng_ruse[1] && (yng_rb == old_rt)) ||
                     (yng_ruse[0] && (yng_rc == old_rt));
  assign split = ep_vld_i && op_vld_i && old_wr &&
                 (yng_reads || (yng_wr && (yng_rt == old_rt)));

  always_comb begin
    state_d    = state_q;
    issue_ep_d = 1'b0;
    issue_op_d = 1'b0;
    ready_d    = 1'b0;
    if (flush_i) begin
      state_d = S_FULL;
    end else if (!rst_i && pair_valid_i) begin
      case (state_q)
        S_FULL: begin
          if (!split) begin
            if (ep_rdy && op_rdy) begin
              issue_ep_d = ep_vld_i;
              issue_op_d = op_vld_i;
              ready_d    = 1'b1;
            end
          end else if (old_rdy) begin
            issue_ep_d = ep_first_i;
            issue_op_d = !ep_first_i;
            state_d    = S_HALF;
          end
        end
        S_HALF: begin
          if (yng_rdy) begin
            issue_ep_d = !ep_first_i && ep_vld_i;
            issue_op_d = ep_first_i && op_vld_i;
            ready_d    = 1'b1;
            state_d    = S_FULL;
          end
        end
        default: state_d = S_FULL;
      endcase
    end
  end

  assign pair_ready_o = ready_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_FULL;
      issue_ep_q <= 1'b0;
      issue_op_q <= 1'b0;
      stall_q    <= '0;
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      state_q    <= state_d;
      issue_ep_q <= issue_ep_d;
      issue_op_q <= issue_op_d;
      if (pair_valid_i && !flush_i && !issue_ep_d && !issue_op_d && (stall_q != '1))
        stall_q <= stall_q + STALL_WD'(1);
      // Same-cycle dual issue never shares rt, so the ep/op priority is arbitrary.
      for (int r = 0; r < NUM_REGS; r++) begin
        if (flush_i)
          cnt_q[r] <= '0;
        else if (issue_ep_d && ep_wr_i && (ep_rt_i == ADDR_WD'(r)))
          cnt_q[r] <= ep_lat_i;
        else if (issue_op_d && op_wr_i && (op_rt_i == ADDR_WD'(r)))
          cnt_q[r] <= op_lat_i;
        else if (cnt_q[r] != '0)
          cnt_q[r] <= cnt_q[r] - LAT_WD'(1);
      end
    end
  end

  assign issue_ep_vld_o = issue_ep_q;
  assign issue_op_vld_o = issue_op_q;
  assign stall_cnt_o    = stall_q;

endmodule
